gate_chk_bist: RTL and testbench



---
 rtl/gate_chk_bist_pkg.sv | 24 ++
 rtl/gate_chk_bist_if.sv | 49 ++++
 rtl/gate_chk_bist_vec_seq.sv | 52 +++++
 rtl/gate_chk_bist.sv | 152 +++++++++++++++
 tb/tb_gate_chk_bist.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_chk_bist_pkg.sv
// gate_chk_pkg
// Shared definitions for the gate self-checker: FSM state encoding, the
// number of input vectors a 2-input gate has, and the expected truth tables
// of the common basic gates.  A truth table is indexed by {a,b}, so bit
// {a,b} holds the output the gate must produce for that input pair.
package gate_chk_pkg;

    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;

    localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
    localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
    localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
    localparam logic [NUM_VEC-1:0] TT_XNOR = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gate_chk_bist_if.sv
// gate_chk_bist_if
// Bundles the run handshake, the gate-under-test drive/sense pins and the
// result signals of gate_chk_bist.
//   start     : one-cycle run request (master -> checker)
//   dut_y     : output of the gate under test (master -> checker)
//   dut_a/b   : registered inputs to the gate under test (checker -> master)
//   busy      : run in progress
//   done      : one-cycle end-of-run pulse
//   pass      : run result, valid with done, held until the next start
//   fail_mask : per-vector mismatch flags, bit {a,b}
//   err_count : saturating mismatch counter, only when GATE_CHK_ERRCNT_EN
//               is defined
interface gate_chk_bist_if;
    import gate_chk_pkg::*;

    logic               start;
    logic               dut_y;
    logic               dut_a;
    logic               dut_b;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_VEC-1:0] fail_mask;

`ifdef GATE_CHK_ERRCNT_EN
    logic [7:0]         err_count;

    modport master (
        output start, dut_y,
        input  dut_a, dut_b, busy, done, pass, fail_mask, err_count
    );

    modport slave (
        input  start, dut_y,
        output dut_a, dut_b, busy, done, pass, fail_mask, err_count
    );
`else
    modport master (
        output start, dut_y,
        input  dut_a, dut_b, busy, done, pass, fail_mask
    );

    modport slave (
        input  start, dut_y,
        output dut_a, dut_b, busy, done, pass, fail_mask
    );
`endif

endinterface

// File: rtl/gate_chk_bist_vec_seq.sv
// gate_chk_vec_seq
// Vector/settle sequencer for the gate self-checker.  Holds the current
// input vector and the settle counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : restart from vector 0 with the settle counter at 0
//   i_advance    : count one settle cycle (high while the run is active)
//   o_vec        : current vector {a,b}
//   o_sample_now : the settle time for o_vec has elapsed this cycle
module gate_chk_vec_seq
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [VEC_W-1:0] o_vec,
    output logic             o_sample_now
);

    logic [VEC_W-1:0] r_vec;
    logic [CNT_W-1:0] r_cnt;

    // The sample point is the cycle whose counter value equals the settle
    // time, so a settle time of 0 samples in the first cycle of a vector.
    assign o_sample_now = (r_cnt == CNT_W'(SETTLE_CYCLES));
    assign o_vec        = r_vec;

    // Each vector spends SETTLE_CYCLES+1 cycles here: the counter runs up to
    // the sample point, then the vector steps on and the counter restarts.
    // Stepping past the last vector wraps to 0, which is harmless because
    // the controller leaves the run at that point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_vec <= '0;
            r_cnt <= '0;
        end else if (i_advance) begin
            if (o_sample_now) begin
                r_vec <= r_vec + VEC_W'(1);
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gate_chk_bist.sv
// gate_chk_bist
// On-chip self-test driver/checker for a 2-input basic gate.  A start
// request walks the four input vectors {a,b} = 00,01,10,11 into the gate,
// waits SETTLE_CYCLES after presenting each one, samples the gate output,
// compares it with TRUTH_TABLE and reports done/pass/fail_mask.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gate_chk_bist_if.slave (start, dut_y in; dut_a, dut_b, busy,
//           done, pass, fail_mask out)
// Parameters:
//   TRUTH_TABLE   : expected y, bit {a,b}
//   SETTLE_CYCLES : cycles between presenting a vector and sampling y (0..15)
//   CNT_W         : settle counter width, must hold SETTLE_CYCLES
// Optional feature macro GATE_CHK_ERRCNT_EN: adds bus.err_count, an 8-bit
// saturating count of mismatching samples across runs, cleared only by
// rst_n.
module gate_chk_bist
    import gate_chk_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] TRUTH_TABLE   = TT_AND,
    parameter int unsigned        SETTLE_CYCLES = 2,
    parameter int unsigned        CNT_W         = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    gate_chk_bist_if.slave bus
);

    state_e             r_state;
    logic               r_dutA;
    logic               r_dutB;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [NUM_VEC-1:0] r_failMask;

    logic               w_clear;
    logic               w_advance;
    logic [VEC_W-1:0]   w_vec;
    logic [VEC_W-1:0]   w_nextVec;
    logic               w_sampleNow;
    logic               w_sampleHit;
    logic               w_mismatch;
    logic [NUM_VEC-1:0] w_failNext;
    logic               w_lastVec;

    // A start is only accepted from IDLE; the sequencer counts only in RUN.
    assign w_clear   = (r_state == IDLE) && bus.start;
    assign w_advance = (r_state == RUN);

    gate_chk_vec_seq #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_vecSeq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_advance    (w_advance),
        .o_vec        (w_vec),
        .o_sample_now (w_sampleNow)
    );

    // Compare the gate output against the expected table at the sample
    // point, and fold the result into the mask that will be registered on
    // this edge so the final vector is already included when pass is
    // computed.
    assign w_sampleHit = w_advance && w_sampleNow;
    assign w_mismatch  = w_sampleHit && (bus.dut_y != TRUTH_TABLE[w_vec]);
    assign w_failNext  = r_failMask | (w_mismatch ? (NUM_VEC'(1) << w_vec) : '0);
    assign w_nextVec   = w_vec + VEC_W'(1);
    assign w_lastVec   = (w_vec == VEC_W'(NUM_VEC - 1));

    // Run controller.  dut_a/dut_b are registered and change on the same
    // edge the sequencer moves to the next vector, so the gate input and
    // the vector being checked stay aligned.  After the last vector the
    // pins simply keep driving 11.  DONE lasts exactly one cycle and does
    // not look at start, so a held start only restarts from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dutA     <= 1'b0;
            r_dutB     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_failMask <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_failMask <= '0;
                        r_dutA     <= 1'b0;
                        r_dutB     <= 1'b0;
                    end
                end
                RUN: begin
                    r_failMask <= w_failNext;
                    if (w_sampleNow) begin
                        if (w_lastVec) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_failNext == '0);
                        end else begin
                            r_dutA <= w_nextVec[1];
                            r_dutB <= w_nextVec[0];
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_a     = r_dutA;
    assign bus.dut_b     = r_dutB;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_mask = r_failMask;

`ifdef GATE_CHK_ERRCNT_EN
    logic [7:0] r_errCount;

    // Lifetime mismatch counter: one count per bad sample, sticking at
    // 8'hFF, and deliberately not cleared by start so it accumulates over
    // many runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCount <= 8'h00;
        end else if (w_mismatch && (r_errCount != 8'hFF)) begin
            r_errCount <= r_errCount + 8'h01;
        end
    end

    assign bus.err_count = r_errCount;
`endif

endmodule

// File: tb/tb_gate_chk_bist.sv
// tb_gate_chk_bist
// Testbench for gate_chk_bist.  Three checker instances share clk, rst_n
// and start:
//   inst0 : TT_AND, SETTLE_CYCLES=2
//   inst1 : TT_XOR, SETTLE_CYCLES=2
//   inst2 : TT_AND, SETTLE_CYCLES=0
// Each instance has its own emulated gate under test, an arbitrary 4-bit
// table gateTT[i] indexed by {a,b}, so tie-0, tie-1 and every basic gate
// can be attached.  A behavioural model counts the edges since an accepted
// start and derives every output arithmetically.  A register written on
// edge k is counted as visible in cycle k+1, with the start edge as cycle 0.
// With GATE_CHK_ERRCNT_EN defined the err_count output is also checked.
module tb_gate_chk_bist;
    import gate_chk_pkg::*;

    localparam int NI = 3;
    localparam logic [3:0] TT_P [NI] = '{TT_AND, TT_XOR, TT_AND};
    localparam int         ST_P [NI] = '{2, 2, 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic [3:0] gateTT   [NI];
    logic       obsA     [NI];
    logic       obsB     [NI];
    logic       obsBusy  [NI];
    logic       obsDone  [NI];
    logic       obsPass  [NI];
    logic [3:0] obsMask  [NI];
    logic [7:0] obsErr   [NI];

    int vecCount  = 0;
    int missCount = 0;

    // Behavioural model state, one entry per instance.
    bit         mRun     [NI];
    int         mJ       [NI];
    logic [3:0] mFull    [NI];
    logic [3:0] mMask    [NI];
    logic       mPass    [NI];
    logic [1:0] mAB      [NI];
    int         mErrBase [NI];
    int         mErr     [NI];
    logic       expBusy  [NI];
    logic       expDone  [NI];

    // Observations collected by runDirected.
    int         dCyc     [NI];
    int         dPulses  [NI];
    logic [1:0] dAB      [20];
    logic       dBusy    [20];

    always #5 clk = ~clk;

    // One checker plus its emulated gate per instance.
    for (genvar g = 0; g < NI; g++) begin : gInst
        gate_chk_bist_if bus ();

        gate_chk_bist #(
            .TRUTH_TABLE   (TT_P[g]),
            .SETTLE_CYCLES (ST_P[g]),
            .CNT_W         (4)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        assign bus.start  = start;
        assign bus.dut_y  = gateTT[g][{bus.dut_a, bus.dut_b}];
        assign obsA[g]    = bus.dut_a;
        assign obsB[g]    = bus.dut_b;
        assign obsBusy[g] = bus.busy;
        assign obsDone[g] = bus.done;
        assign obsPass[g] = bus.pass;
        assign obsMask[g] = bus.fail_mask;
`ifdef GATE_CHK_ERRCNT_EN
        assign obsErr[g]  = bus.err_count;
`else
        assign obsErr[g]  = 8'h00;
`endif
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [7:0] act, input logic [7:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s inst%0d: got %0h, want %0h at %0t",
                     name, inst, act, exp, $time);
        end
    endtask

    function automatic int popCount4(input logic [3:0] v);
        int n = 0;
        for (int b = 0; b < 4; b++) n += int'(v[b]);
        return n;
    endfunction

    // Advance the model by one clock edge.  A run lasts L = 4*(S+1) edges of
    // vector time plus the DONE edge; j counts edges since the start edge.
    // By edge j, floor(j/(S+1)) vectors have been sampled, and the mask is
    // the full mismatch set restricted to those vectors.
    function automatic void modelStep(input int i);
        int L;
        int n;
        int lim;
        L = 4 * (ST_P[i] + 1);
        if (!rst_n) begin
            mRun[i] = 1'b0;  mJ[i] = 0;      mMask[i] = 4'h0;
            mPass[i] = 1'b0; mAB[i] = 2'd0;  mErrBase[i] = 0;
            mErr[i] = 0;     expBusy[i] = 1'b0; expDone[i] = 1'b0;
            return;
        end
        if (!mRun[i]) begin
            expDone[i] = 1'b0;
            expBusy[i] = 1'b0;
            if (start) begin
                mRun[i]    = 1'b1;
                mJ[i]      = 0;
                mFull[i]   = TT_P[i] ^ gateTT[i];
                mMask[i]   = 4'h0;
                mPass[i]   = 1'b0;
                mAB[i]     = 2'd0;
                expBusy[i] = 1'b1;
            end
        end else begin
            mJ[i]++;
            if (mJ[i] > L) begin
                mRun[i]     = 1'b0;
                expBusy[i]  = 1'b0;
                expDone[i]  = 1'b0;
                mErrBase[i] = mErr[i];
            end else begin
                n   = mJ[i] / (ST_P[i] + 1);
                lim = (1 << n) - 1;
                mMask[i]   = mFull[i] & 4'(lim);
                mErr[i]    = mErrBase[i] + popCount4(mMask[i]);
                if (mErr[i] > 255) mErr[i] = 255;
                expBusy[i] = (mJ[i] < L);
                expDone[i] = (mJ[i] == L);
                mAB[i]     = (mJ[i] < L) ? 2'(n) : 2'd3;
                if (mJ[i] == L) mPass[i] = (mFull[i] == 4'h0);
            end
        end
    endfunction

    // Compare every instance against the model just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            modelStep(i);
            checkOutput("dut_ab", i, 8'({obsA[i], obsB[i]}), 8'(mAB[i]));
            checkOutput("busy", i, 8'(obsBusy[i]), 8'(expBusy[i]));
            checkOutput("done", i, 8'(obsDone[i]), 8'(expDone[i]));
            checkOutput("pass", i, 8'(obsPass[i]), 8'(mPass[i]));
            checkOutput("fail_mask", i, 8'(obsMask[i]), 8'(mMask[i]));
`ifdef GATE_CHK_ERRCNT_EN
            checkOutput("err_count", i, obsErr[i], 8'(mErr[i]));
`endif
        end
    end

    // Raise start for the start edge (cycle 0) and watch 20 edges.  start
    // stays high if holdStart, and is pulsed again for the edge after
    // sample k == extraAt.  Records the first done cycle and done pulse
    // count per instance, plus the inst0 pin and busy traces.
    task automatic applyStimulus(input bit holdStart, input int extraAt);
        for (int i = 0; i < NI; i++) begin
            dCyc[i]    = 0;
            dPulses[i] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            dAB[k]   = {obsA[0], obsB[0]};
            dBusy[k] = obsBusy[0];
            for (int i = 0; i < NI; i++) begin
                if (obsDone[i] === 1'b1) begin
                    dPulses[i]++;
                    if (dCyc[i] == 0) dCyc[i] = k + 1;
                end
            end
            @(negedge clk);
            start = holdStart || (k == extraAt);
        end
        start = 1'b0;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setGates(input logic [3:0] tt);
        for (int i = 0; i < NI; i++) gateTT[i] = tt;
    endtask

    initial begin
        int doneSeen;
        setGates(TT_AND);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_busy", 0, 8'(obsBusy[0]), 8'h0);
        checkOutput("reset_done", 0, 8'(obsDone[0]), 8'h0);
        checkOutput("reset_ab", 0, 8'({obsA[0], obsB[0]}), 8'h0);
        checkOutput("reset_mask", 0, 8'(obsMask[0]), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] AND gate on AND/XOR tables, settle 2 and 0");
        applyStimulus(1'b0, -1);
        checkOutput("and_done_cycle", 0, 8'(dCyc[0]), 8'd13);
        checkOutput("and_pass", 0, 8'(obsPass[0]), 8'h1);
        checkOutput("and_mask", 0, 8'(obsMask[0]), 8'h0);
        checkOutput("xor_vs_and_pass", 1, 8'(obsPass[1]), 8'h0);
        checkOutput("xor_vs_and_mask", 1, 8'(obsMask[1]), 8'b1110);
        checkOutput("s0_done_cycle", 2, 8'(dCyc[2]), 8'd5);
        checkOutput("s0_pass", 2, 8'(obsPass[2]), 8'h1);
        for (int k = 0; k < 13; k++) begin
            checkOutput("ab_sequence", 0, 8'(dAB[k]), 8'((k < 12) ? k / 3 : 3));
        end

        $display("[TB] output tied low");
        setGates(4'h0);
        applyStimulus(1'b0, -1);
        checkOutput("tie0_pass", 0, 8'(obsPass[0]), 8'h0);
        checkOutput("tie0_mask", 0, 8'(obsMask[0]), 8'b1000);
        checkOutput("tie0_xor_mask", 1, 8'(obsMask[1]), 8'b0110);

        $display("[TB] reset during vector 2");
        setGates(4'hF);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("pre_reset_mask", 0, 8'(obsMask[0]), 8'b0011);
        checkOutput("pre_reset_ab", 0, 8'({obsA[0], obsB[0]}), 8'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 0, 8'(obsBusy[0]), 8'h0);
        checkOutput("abort_mask", 0, 8'(obsMask[0]), 8'h0);
        checkOutput("abort_ab", 0, 8'({obsA[0], obsB[0]}), 8'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (obsDone[0] === 1'b1) doneSeen++;
        end
        checkOutput("abort_no_done", 0, 8'(doneSeen), 8'h0);
        setGates(TT_AND);
        applyStimulus(1'b0, -1);
        checkOutput("rerun_done_cycle", 0, 8'(dCyc[0]), 8'd13);
        checkOutput("rerun_pass", 0, 8'(obsPass[0]), 8'h1);

        $display("[TB] start held high");
        applyStimulus(1'b1, -1);
        checkOutput("hold_done_pulses", 0, 8'(dPulses[0]), 8'd1);
        checkOutput("hold_done_cycle", 0, 8'(dCyc[0]), 8'd13);
        checkOutput("hold_busy_done", 0, 8'(dBusy[12]), 8'h0);
        checkOutput("hold_busy_idle", 0, 8'(dBusy[13]), 8'h0);
        checkOutput("hold_busy_rerun", 0, 8'(dBusy[14]), 8'h1);
        repeat (30) @(negedge clk);

        $display("[TB] extra start pulse mid-run");
        applyStimulus(1'b0, 5);
        checkOutput("extra_done_pulses", 0, 8'(dPulses[0]), 8'd1);
        checkOutput("extra_done_cycle", 0, 8'(dCyc[0]), 8'd13);
        repeat (20) @(negedge clk);

`ifdef GATE_CHK_ERRCNT_EN
        $display("[TB] error counter over three runs, output tied high");
        resetPulse();
        setGates(4'hF);
        repeat (3) applyStimulus(1'b0, -1);
        checkOutput("errcnt_and", 0, obsErr[0], 8'd9);
        checkOutput("errcnt_xor", 1, obsErr[1], 8'd6);
        checkOutput("errcnt_s0", 2, obsErr[2], 8'd9);
        repeat (10) @(negedge clk);
`endif

        $display("[TB] randomized runs");
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NI; i++) gateTT[i] = 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(0, 11)) @(negedge clk);
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                applyStimulus(($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 15)));
            end
            repeat (32) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
